// File: rtl/rr_arb4_ctrl.sv
// rtl/rr_arb4_ctrl.sv - four-way round-robin arbiter with hold limit and one dead cycle between grants
// The grant outputs are registered directly from the next-state logic, so downstream logic sees glitch-free codes.
module rr_arb4_ctrl #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] rel,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        REL     = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0]       ptr, ptr_d;
    logic [3:0]       gnt_d;
    logic [1:0]       gnt_id_d;
    logic             gnt_vld_d;
    logic             timeout_d;

    logic [1:0]       win;
    logic             win_vld;
    logic [1:0]       idx;
    logic             owner_done;

    // Scan from the farthest offset down so the offset nearest ptr is written last and wins.
    always_comb begin
        win     = ptr;
        win_vld = 1'b0;
        idx     = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign owner_done = rel[gnt_id] || !req[gnt_id];

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ptr_d     = ptr;
        gnt_d     = gnt;
        gnt_id_d  = gnt_id;
        gnt_vld_d = gnt_vld;
        timeout_d = 1'b0;
        case (state)
            IDLE, REL: begin
                state_d   = IDLE;
                gnt_d     = 4'b0000;
                gnt_id_d  = 2'b00;
                gnt_vld_d = 1'b0;
                if (win_vld) begin
                    state_d   = BUSY;
                    gnt_d     = 4'b0001 << win;
                    gnt_id_d  = win;
                    gnt_vld_d = 1'b1;
                    cnt_d     = '0;
                    ptr_d     = win + 2'd1;
                end
            end
            BUSY: begin
                if (cnt != CNT_TOP) begin
                    cnt_d = cnt + 1'b1;
                end
                // A release in the same cycle as the hold limit is a normal release, not a timeout.
                if (owner_done || cnt == LIMIT) begin
                    state_d   = REL;
                    gnt_d     = 4'b0000;
                    gnt_id_d  = 2'b00;
                    gnt_vld_d = 1'b0;
                    timeout_d = !owner_done;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                gnt_d     = 4'b0000;
                gnt_id_d  = 2'b00;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= 2'b00;
            gnt     <= 4'b0000;
            gnt_id  <= 2'b00;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            ptr     <= ptr_d;
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            gnt_vld <= gnt_vld_d;
            timeout <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// tb/tb_rr_arb4_ctrl.sv - self-checking bench for rr_arb4_ctrl against an owner/hold-time model
module tb_rr_arb4_ctrl;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] rel = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_arb4_ctrl #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the resource, for how many cycles, and where the search starts next.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    always @(posedge clk or negedge rst) begin : model
        int pick;
        if (!rst) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
            m_to    = 1'b0;
        end else if (m_owner >= 0) begin
            m_to   = 1'b0;
            m_held = m_held + 1;
            if (rel[m_owner] || !req[m_owner]) begin
                m_owner = -1;
            end else if (m_held == HOLD) begin
                m_owner = -1;
                m_to    = 1'b1;
            end
        end else begin
            m_to = 1'b0;
            pick = -1;
            for (int k = 0; k < 4; k++) begin
                if (pick < 0 && req[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_held  = 0;
                m_ptr   = (pick + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin
        check("mdl_gnt",     32'(gnt),     (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check("mdl_gnt_id",  32'(gnt_id),  (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("mdl_gnt_vld", 32'(gnt_vld), 32'(m_owner >= 0));
        check("mdl_timeout", 32'(timeout), 32'(m_to));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] id, input logic to);
        check({name, "_gnt"},     32'(gnt),     32'(g));
        check({name, "_gnt_id"},  32'(gnt_id),  32'(id));
        check({name, "_gnt_vld"}, 32'(gnt_vld), 32'(g != 4'b0000));
        check({name, "_timeout"}, 32'(timeout), 32'(to));
    endtask

    initial begin
        req = 4'b1111;
        repeat (3) cyc();
        expect_out("in_reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b1;

        // Round robin with each owner releasing on its second grant cycle.
        for (int k = 0; k < 5; k++) begin
            logic [1:0] id;
            id = 2'(k % 4);
            cyc();
            expect_out("rr_first", 4'b0001 << id, id, 1'b0);
            cyc();
            expect_out("rr_second", 4'b0001 << id, id, 1'b0);
            rel = 4'b0001 << id;
            cyc();
            rel = 4'b0000;
            expect_out("rr_dead", 4'b0000, 2'd0, 1'b0);
        end
        req = 4'b0000;
        cyc();
        expect_out("rr_idle", 4'b0000, 2'd0, 1'b0);

        // Single requester, released on its third grant cycle.
        req = 4'b0100;
        cyc(); expect_out("single_c1", 4'b0100, 2'd2, 1'b0);
        cyc(); expect_out("single_c2", 4'b0100, 2'd2, 1'b0);
        cyc(); expect_out("single_c3", 4'b0100, 2'd2, 1'b0);
        rel = 4'b0100;
        req = 4'b0000;
        cyc(); expect_out("single_rel", 4'b0000, 2'd0, 1'b0);
        rel = 4'b0000;
        cyc(); expect_out("single_idle", 4'b0000, 2'd0, 1'b0);

        // Hold-limit revoke, then immediate regrant to the same lone requester.
        req = 4'b0010;
        for (int i = 0; i < HOLD; i++) begin
            cyc();
            expect_out("hold", 4'b0010, 2'd1, 1'b0);
        end
        cyc(); expect_out("to_dead", 4'b0000, 2'd0, 1'b1);
        cyc(); expect_out("to_regrant", 4'b0010, 2'd1, 1'b0);
        cyc(); expect_out("nonowner_c2", 4'b0010, 2'd1, 1'b0);
        rel = 4'b1101;
        cyc(); expect_out("nonowner_c3", 4'b0010, 2'd1, 1'b0);
        rel = 4'b0000;
        cyc(); expect_out("rel_at_limit_c4", 4'b0010, 2'd1, 1'b0);
        rel = 4'b0010;
        cyc(); expect_out("rel_beats_to", 4'b0000, 2'd0, 1'b0);
        rel = 4'b0000;
        req = 4'b0000;
        cyc(); expect_out("to_idle", 4'b0000, 2'd0, 1'b0);

        // Asynchronous reset while requester 3 owns the resource.
        req = 4'b1000;
        cyc(); expect_out("own3", 4'b1000, 2'd3, 1'b0);
        req = 4'b1001;
        #2;
        rst = 1'b0;
        #1;
        expect_out("async_rst", 4'b0000, 2'd0, 1'b0);
        cyc();
        rst = 1'b1;
        cyc(); expect_out("post_rst", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        cyc();
        cyc(); expect_out("post_rst_idle", 4'b0000, 2'd0, 1'b0);

        // Reset while ptr points at 3: the next grant must restart from requester 0.
        req = 4'b0100;
        cyc(); expect_out("own2", 4'b0100, 2'd2, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        req = 4'b1001;
        cyc();
        rst = 1'b1;
        cyc(); expect_out("ptr_reset", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb4_ctrl.md
Name: rr_arb4_ctrl

Overview:
- Round-robin arbiter/controller that shares one 2-bit-coded datapath resource among four requesters.
- Grants one requester at a time. Emits the winner both as a one-hot grant and as a 2-bit index, which drives the downstream 2-bit din-style code input.
- Enforces a maximum hold time per grant and inserts one dead cycle between grants, so the downstream state machine never sees back-to-back owner changes.

Parameters:
- HOLD_MAX, 8, maximum consecutive cycles a requester may hold the grant (legal range 1..2**CNT_W).
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset: 0 resets immediately; release is sampled on clk.
- req  input  4  request vector, bit i = requester i; level-sensitive, held until served.
- rel  input  4  release strobe, bit i = requester i done; only the bit of the current owner is honoured.
- gnt  output  4  one-hot grant, registered; all-zero when no owner.
- gnt_id  output  2  index of current owner, registered; 2'b00 when no owner.
- gnt_vld  output  1  1 while gnt is non-zero.
- timeout  output  1  one-cycle pulse, registered; asserted when a grant was revoked by the hold limit.

Behaviour:
- Reset (rst=0, async): state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_vld=0, timeout=0, cnt=0, ptr=2'b00.
- State register: 2-bit, states IDLE=00, BUSY=01, REL=10. Code 11 is illegal and goes to IDLE on the next edge with all outputs cleared.
- Arbitration (combinational, used in IDLE and REL):
  - Search req starting at index ptr, then ptr+1, ptr+2, ptr+3, all mod 4.
  - The first set bit wins.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise, on the next edge: state=BUSY, gnt=onehot(winner), gnt_id=winner, gnt_vld=1, cnt=0, ptr=winner+1 mod 4.
  - Grant latency from the first sampled req is exactly 1 cycle.
- BUSY:
  - Each cycle cnt increments; it saturates and never wraps.
  - Release condition: rel[gnt_id]=1 OR req[gnt_id]=0. On the next edge: state=REL, gnt=0, gnt_id=0, gnt_vld=0, timeout=0.
  - Timeout condition: cnt==HOLD_MAX-1 with no release condition. On the next edge: state=REL, outputs cleared as above, timeout=1.
  - If release and timeout occur in the same cycle, release has priority and timeout stays 0.
  - rel bits of non-owners are ignored. req changes of non-owners do not affect BUSY.
- REL:
  - Lasts exactly one cycle (the dead cycle); timeout returns to 0 after it.
  - Arbitrate with the updated ptr.
  - req!=0: next edge goes to BUSY with the new grant, same rules as IDLE.
  - req==0: next edge goes to IDLE.
  - A timed-out requester that still holds req competes normally; it gets lowest priority because ptr has moved past it.
- Throughput: each grant occupies hold cycles plus 1 dead cycle. With all four requesting continuously, the order is 0,1,2,3,0,...
- Fairness: no requester waits more than 3 full grants once its req is asserted.
- Reset mid-grant: outputs clear immediately (async) and ptr returns to 0. The first grant after reset release follows IDLE rules.
- HOLD_MAX=1: every grant lasts exactly 1 cycle. Timeout pulses unless the owner releases in that cycle.

Test Plan:
- Reset check: hold rst=0 with req=4'b1111 -> gnt=0000, gnt_id=00, gnt_vld=0, timeout=0. Release rst -> one cycle later gnt=0001, gnt_id=00.
- Single requester: req=4'b0100 at cycle 0; rel[2] pulsed at cycle 3 -> gnt=0100 during cycles 1-3, 0000 at cycle 4 (REL), IDLE at cycle 5, timeout never asserted.
- Round robin: req=4'b1111 constant, each owner pulses rel on its second grant cycle -> gnt_id sequence 0,1,2,3,0, with one gnt=0000 cycle between consecutive grants.
- Timeout: HOLD_MAX=4, req=4'b0010 held, no rel -> gnt=0010 for exactly 4 cycles, then gnt=0000 with timeout=1 for 1 cycle, then gnt=0010 again.
- Simultaneous release and timeout: HOLD_MAX=4, owner asserts rel in its 4th grant cycle -> REL entered with timeout=0. Also: rel asserted by a non-owner -> no effect on gnt.
- Reset mid-operation: drive rst=0 between clock edges while gnt=1000 -> gnt=0000 immediately. After release with req=4'b1001 -> first grant goes to requester 0 (ptr reset), not 3.
